// File: rtl/vote_session_ctrl_if.sv
// Ballot handshake bundle between the ballot source (master) and vote_session_ctrl (slave).
interface vote_session_ctrl_if;
  logic       ballot_valid;
  logic       ballot_ready;
  logic [1:0] ballot_class;
  logic [4:0] ballot_id;
  logic       ballot_yes;

  modport master (
    output ballot_valid,
    output ballot_class,
    output ballot_id,
    output ballot_yes,
    input  ballot_ready
  );

  modport slave (
    input  ballot_valid,
    input  ballot_class,
    input  ballot_id,
    input  ballot_yes,
    output ballot_ready
  );
endinterface

// File: rtl/vote_session_ctrl.sv
// Weighted-vote session controller: collects one ballot per cycle, rejects duplicates and
// out-of-range voters, keeps core-ready yes vectors and a running tally, latches pass/fail.
module vote_session_ctrl #(
  parameter int THRESH     = 41,
  parameter int W_VIP      = 4,
  parameter int W_VVIP     = 16,
  parameter int AUTO_CLOSE = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_close,
  vote_session_ctrl_if.slave   ballot,
  output logic [31:0]          o_np_vec,
  output logic [7:0]           o_vip_vec,
  output logic                 o_vvip_bit,
  output logic [6:0]           o_tally,
  output logic [5:0]           o_voted_cnt,
  output logic                 o_rej_err,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_result
);

  localparam int NUM_VOTERS = 41;

  typedef enum logic [1:0] {
    S_IDLE,
    S_OPEN,
    S_TALLY,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        w_open_session;

  logic [31:0] r_np_vec;
  logic [7:0]  r_vip_vec;
  logic        r_vvip_bit;
  logic [31:0] r_np_voted;
  logic [7:0]  r_vip_voted;
  logic        r_vvip_voted;
  logic [6:0]  r_tally;
  logic [5:0]  r_voted_cnt;
  logic        r_rej_err;
  logic        r_result;

  logic        w_fire;
  logic        w_legal;
  logic        w_dup;
  logic        w_accept;
  logic        w_last_voter;

  // Range check and duplicate lookup for the ballot currently on the bus.
  always_comb begin
    w_legal = 1'b0;
    w_dup   = 1'b0;
    case (ballot.ballot_class)
      2'd0: begin
        w_legal = 1'b1;
        w_dup   = r_np_voted[ballot.ballot_id];
      end
      2'd1: begin
        w_legal = (ballot.ballot_id < 5'd8);
        w_dup   = r_vip_voted[ballot.ballot_id[2:0]];
      end
      2'd2: begin
        w_legal = (ballot.ballot_id == 5'd0);
        w_dup   = r_vvip_voted;
      end
      default: begin
        w_legal = 1'b0;
        w_dup   = 1'b0;
      end
    endcase
  end

  assign w_fire       = ballot.ballot_valid && (r_state == S_OPEN);
  assign w_accept     = w_fire && w_legal && !w_dup;
  assign w_last_voter = (AUTO_CLOSE != 0) && w_accept &&
                        (r_voted_cnt == 6'(NUM_VOTERS - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Close beats start in OPEN; a ballot in the closing cycle still lands before TALLY.
  always_comb begin
    w_next_state   = r_state;
    w_open_session = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next_state   = S_OPEN;
          w_open_session = 1'b1;
        end
      end
      S_OPEN: begin
        if (i_close || w_last_voter) begin
          w_next_state = S_TALLY;
        end
      end
      S_TALLY: begin
        w_next_state = S_DONE;
      end
      S_DONE: begin
        if (i_start) begin
          w_next_state   = S_OPEN;
          w_open_session = 1'b1;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_np_vec     <= '0;
      r_vip_vec    <= '0;
      r_vvip_bit   <= 1'b0;
      r_np_voted   <= '0;
      r_vip_voted  <= '0;
      r_vvip_voted <= 1'b0;
      r_tally      <= '0;
      r_voted_cnt  <= '0;
      r_rej_err    <= 1'b0;
      r_result     <= 1'b0;
    end else begin
      r_rej_err <= w_fire && !w_accept;
      if (w_open_session) begin
        r_np_vec     <= '0;
        r_vip_vec    <= '0;
        r_vvip_bit   <= 1'b0;
        r_np_voted   <= '0;
        r_vip_voted  <= '0;
        r_vvip_voted <= 1'b0;
        r_tally      <= '0;
        r_voted_cnt  <= '0;
        r_result     <= 1'b0;
      end else if (r_state == S_TALLY) begin
        r_result <= (r_tally >= 7'(THRESH));
      end else if (w_accept) begin
        r_voted_cnt <= r_voted_cnt + 6'd1;
        case (ballot.ballot_class)
          2'd0: begin
            r_np_voted[ballot.ballot_id] <= 1'b1;
            if (ballot.ballot_yes) begin
              r_np_vec[ballot.ballot_id] <= 1'b1;
              r_tally                    <= r_tally + 7'd1;
            end
          end
          2'd1: begin
            r_vip_voted[ballot.ballot_id[2:0]] <= 1'b1;
            if (ballot.ballot_yes) begin
              r_vip_vec[ballot.ballot_id[2:0]] <= 1'b1;
              r_tally                          <= r_tally + 7'(W_VIP);
            end
          end
          2'd2: begin
            r_vvip_voted <= 1'b1;
            if (ballot.ballot_yes) begin
              r_vvip_bit <= 1'b1;
              r_tally    <= r_tally + 7'(W_VVIP);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign ballot.ballot_ready = (r_state == S_OPEN);
  assign o_busy              = (r_state == S_OPEN) || (r_state == S_TALLY);
  assign o_done              = (r_state == S_DONE);
  assign o_np_vec            = r_np_vec;
  assign o_vip_vec           = r_vip_vec;
  assign o_vvip_bit          = r_vvip_bit;
  assign o_tally             = r_tally;
  assign o_voted_cnt         = r_voted_cnt;
  assign o_rej_err           = r_rej_err;
  assign o_result            = r_result;

endmodule
